// File: rtl/adder_sched.sv
// adder_sched: round-robin scheduler sharing one 8-bit adder (a + b + carry) among N_REQ
// requesters, with carry chaining across multi-byte locked operations. Optional: ADDER_SCHED_TIMEOUT_EN.
module adder_sched #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_sum,
    output logic                 rsp_cout,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SUM_W  = DATA_W + 1;

    // Elaboration-time sanity checks on the configuration.
    if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
        $error("adder_sched: N_REQ must be in 2..4");
    end
    if ((1 << ID_W) < N_REQ) begin : g_bad_id_w
        $error("adder_sched: ID_W too narrow for N_REQ");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("adder_sched: TIMEOUT must be at least 1");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     owner, owner_nxt;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic                carry_reg, carry_nxt;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [N_REQ-1:0]    grant_mask;
    logic [N_REQ-1:0]    owner_mask;
    logic [ID_W-1:0]     sel_idx;
    logic                accept;
    logic [DATA_W-1:0]   a_sel, b_sel;
    logic                last_sel;
    logic [SUM_W-1:0]    sum;

    logic [N_REQ-1:0]    rsp_valid_nxt;
    logic [DATA_W-1:0]   rsp_sum_nxt;
    logic                rsp_cout_nxt;
    logic [ID_W-1:0]     rsp_id_nxt;
    logic                busy_nxt;

`ifdef ADDER_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    stall_cnt, stall_cnt_nxt;
    logic                timeout_err_nxt;
`endif

    // Arbitration, operand select and the shared 9-bit adder.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_mask  = '0;
        owner_mask  = '0;
        req_ready   = '0;
        sel_idx     = '0;
        a_sel       = '0;
        b_sel       = '0;
        last_sel    = 1'b0;

        // Search rr_ptr+1, rr_ptr+2, ... modulo N_REQ for the first valid requester.
        for (int k = 1; k <= int'(N_REQ); k++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!grant_found && req_valid[i]
                    && (((int'(rr_ptr) + k) % int'(N_REQ)) == i)) begin
                    grant_found = 1'b1;
                    grant_idx   = ID_W'(i);
                end
            end
        end

        for (int i = 0; i < int'(N_REQ); i++) begin
            owner_mask[i] = (owner == ID_W'(i));
            grant_mask[i] = grant_found && (grant_idx == ID_W'(i));
        end

        if (state == LOCKED) begin
            sel_idx   = owner;
            req_ready = req_valid & owner_mask;
        end else begin
            sel_idx   = grant_idx;
            req_ready = grant_mask;
        end

        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_ready[i]) begin
                a_sel    = req_a[DATA_W*i +: DATA_W];
                b_sel    = req_b[DATA_W*i +: DATA_W];
                last_sel = req_last[i];
            end
        end

        accept = |(req_valid & req_ready);
        sum    = SUM_W'(a_sel) + SUM_W'(b_sel) + SUM_W'(carry_reg);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        carry_nxt     = carry_reg;
        rsp_valid_nxt = '0;
        rsp_sum_nxt   = rsp_sum;
        rsp_cout_nxt  = rsp_cout;
        rsp_id_nxt    = rsp_id;
`ifdef ADDER_SCHED_TIMEOUT_EN
        stall_cnt_nxt   = stall_cnt;
        timeout_err_nxt = 1'b0;
`endif

        if (accept) begin
            rsp_valid_nxt = req_ready;
            rsp_sum_nxt   = sum[DATA_W-1:0];
            rsp_cout_nxt  = sum[DATA_W];
            rsp_id_nxt    = sel_idx;
`ifdef ADDER_SCHED_TIMEOUT_EN
            stall_cnt_nxt = '0;
`endif
            if (last_sel) begin
                carry_nxt  = 1'b0;
                state_nxt  = IDLE;
                rr_ptr_nxt = sel_idx;
            end else begin
                carry_nxt  = sum[DATA_W];
                state_nxt  = LOCKED;
                owner_nxt  = sel_idx;
            end
        end
`ifdef ADDER_SCHED_TIMEOUT_EN
        else if (state == LOCKED) begin
            // Owner stalled: abort the lock once the stall reaches TIMEOUT cycles.
            if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                state_nxt       = IDLE;
                carry_nxt       = 1'b0;
                rr_ptr_nxt      = owner;
                stall_cnt_nxt   = '0;
                timeout_err_nxt = 1'b1;
            end else begin
                stall_cnt_nxt = stall_cnt + CNT_W'(1);
            end
        end
`endif

        busy_nxt = (state_nxt == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= ID_W'(N_REQ - 1);
            carry_reg <= 1'b0;
            rsp_valid <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            carry_reg <= carry_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_sum   <= rsp_sum_nxt;
            rsp_cout  <= rsp_cout_nxt;
            rsp_id    <= rsp_id_nxt;
            busy      <= busy_nxt;
        end
    end

`ifdef ADDER_SCHED_TIMEOUT_EN
    // Lock-stall counter and abort strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            stall_cnt   <= stall_cnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// Self-checking bench for adder_sched: directed scenarios plus randomized traffic
// against a behavioural scheduler model (timeout scenario only with ADDER_SCHED_TIMEOUT_EN).
module tb_adder_sched;
    localparam int unsigned N_REQ   = 2;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned TIMEOUT = 15;

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [8*N_REQ-1:0]   req_a;
    logic [8*N_REQ-1:0]   req_b;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ-1:0]     rsp_valid;
    logic [7:0]           rsp_sum;
    logic                 rsp_cout;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;
    logic                 timeout_err;

    int checks = 0;
    int errors = 0;

    adder_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_id(rsp_id), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_last  = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic l);
        req_valid[i]     = v;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_last[i]      = l;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
        checks++; if (rsp_sum !== 8'd0) begin errors++; $display("FAIL reset_rsp_sum got %0d exp 0", rsp_sum); end
        checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_rsp_cout got %b exp 0", rsp_cout); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL idle_no_rsp got %b exp 00", rsp_valid); end
    endtask

    task automatic test_single_byte();
        set_req(0, 1'b1, 8'd12, 8'd7, 1'b1);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
        tick();
        clear_reqs();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_valid got %b exp 01", rsp_valid); end
        checks++; if (rsp_sum !== 8'd19) begin errors++; $display("FAIL single_sum got %0d exp 19", rsp_sum); end
        checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL single_cout got %b exp 0", rsp_cout); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d exp 0", rsp_id); end
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_strobe_len got %b exp 00", rsp_valid); end
    endtask

    task automatic test_overflow();
        set_req(1, 1'b1, 8'd255, 8'd1, 1'b1);
        tick();
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL ovf_valid got %b exp 10", rsp_valid); end
        checks++; if (rsp_sum !== 8'd0) begin errors++; $display("FAIL ovf_sum got %0d exp 0", rsp_sum); end
        checks++; if (rsp_cout !== 1'b1) begin errors++; $display("FAIL ovf_cout got %b exp 1", rsp_cout); end
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL ovf_id got %0d exp 1", rsp_id); end
        set_req(1, 1'b1, 8'd240, 8'd15, 1'b1);
        tick();
        clear_reqs();
        checks++; if (rsp_sum !== 8'd255) begin errors++; $display("FAIL ovf_next_sum got %0d exp 255", rsp_sum); end
        checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL ovf_next_cout got %b exp 0", rsp_cout); end
        tick();
    endtask

    task automatic test_chain();
        set_req(0, 1'b1, 8'hFF, 8'h01, 1'b0);
        set_req(1, 1'b1, 8'd3, 8'd4, 1'b1);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL chain_ready0 got %b exp 01", req_ready); end
        tick();
        checks++; if (rsp_sum !== 8'h00 || rsp_cout !== 1'b1 || rsp_valid !== 2'b01) begin
            errors++; $display("FAIL chain_byte0 got sum %0h cout %b v %b exp 00 1 01", rsp_sum, rsp_cout, rsp_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chain_busy1 got %b exp 1", busy); end
        set_req(0, 1'b1, 8'h00, 8'h00, 1'b1);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL chain_ready1 got %b exp 01", req_ready); end
        tick();
        set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
        checks++; if (rsp_sum !== 8'h01 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL chain_byte1 got sum %0h cout %b id %0d exp 01 0 0", rsp_sum, rsp_cout, rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chain_busy0 got %b exp 0", busy); end
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL chain_ready_req1 got %b exp 10", req_ready); end
        tick();
        clear_reqs();
        checks++; if (rsp_valid !== 2'b10 || rsp_sum !== 8'd7 || rsp_id !== 2'd1) begin
            errors++; $display("FAIL chain_req1 got v %b sum %0d id %0d exp 10 7 1", rsp_valid, rsp_sum, rsp_id); end
        tick();
    endtask

    task automatic test_fairness();
        logic [7:0] a[N_REQ];
        logic [7:0] b[N_REQ];
        int exp_g;
        int total;
        do_reset();
        for (int i = 0; i < int'(N_REQ); i++) begin
            a[i] = 8'($urandom_range(0, 255));
            b[i] = 8'($urandom_range(0, 255));
            set_req(i, 1'b1, a[i], b[i], 1'b1);
        end
        for (int n = 0; n < 4; n++) begin
            exp_g = n % 2;
            total = int'(a[exp_g]) + int'(b[exp_g]);
            #1;
            checks++; if (req_ready !== 2'(1 << exp_g)) begin
                errors++; $display("FAIL fair_ready[%0d] got %b exp grant %0d", n, req_ready, exp_g); end
            tick();
            checks++; if (rsp_id !== ID_W'(exp_g) || rsp_sum !== 8'(total) || rsp_cout !== 1'(total >> 8)) begin
                errors++; $display("FAIL fair_rsp[%0d] got id %0d sum %0d cout %b exp %0d %0d %0d",
                                   n, rsp_id, rsp_sum, rsp_cout, exp_g, total % 256, total / 256); end
            a[exp_g] = 8'($urandom_range(0, 255));
            b[exp_g] = 8'($urandom_range(0, 255));
            set_req(exp_g, 1'b1, a[exp_g], b[exp_g], 1'b1);
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_reset_mid_lock();
        logic [7:0] pa[2];
        logic [7:0] pb[2];
        pa[0] = 8'd170; pb[0] = 8'd85;
        pa[1] = 8'd200; pb[1] = 8'd100;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            set_req(0, 1'b1, pa[p], pb[p], 1'b0);
            tick();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midlock_busy[%0d] got %b exp 1", p, busy); end
            clear_reqs();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_cout !== 1'b0) begin
                errors++; $display("FAIL midlock_after_rst[%0d] got busy %b v %b cout %b exp 0 00 0", p, busy, rsp_valid, rsp_cout); end
            set_req(0, 1'b1, 8'd1, 8'd1, 1'b1);
            tick();
            clear_reqs();
            checks++; if (rsp_sum !== 8'd2 || rsp_valid !== 2'b01) begin
                errors++; $display("FAIL midlock_carry_clr[%0d] got sum %0d v %b exp 2 01", p, rsp_sum, rsp_valid); end
        end
        tick();
    endtask

`ifdef ADDER_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit found;
        int hit;
        do_reset();
        set_req(0, 1'b1, 8'h80, 8'h80, 1'b0);
        set_req(1, 1'b1, 8'd5, 8'd6, 1'b1);
        tick();
        set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL to_locked_ready got %b exp 00", req_ready); end
        found = 1'b0;
        hit   = 0;
        for (int n = 1; n <= 40 && !found; n++) begin
            tick();
            if (timeout_err === 1'b1) begin
                found = 1'b1;
                hit   = n;
            end
        end
        checks++; if (!found || hit != int'(TIMEOUT)) begin
            errors++; $display("FAIL to_delay got found %b after %0d cycles exp after %0d", found, hit, TIMEOUT); end
        checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL to_abort_state got busy %b v %b exp 0 00", busy, rsp_valid); end
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL to_next_grant got %b exp 10", req_ready); end
        tick();
        clear_reqs();
        checks++; if (rsp_valid !== 2'b10 || rsp_sum !== 8'd11 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_after got v %b sum %0d terr %b exp 10 11 0", rsp_valid, rsp_sum, timeout_err); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [N_REQ-1:0] v;
        logic [N_REQ-1:0] l;
        logic [N_REQ-1:0] hold;
        logic [N_REQ-1:0] exp_ready;
        logic [7:0]       a[N_REQ];
        logic [7:0]       b[N_REQ];
        bit m_locked;
        bit exp_to;
        int m_owner, m_carry, m_rr, m_stall;
        int g, total, exp_sum, exp_cout;
        do_reset();
        m_locked = 1'b0; m_owner = 0; m_carry = 0; m_rr = int'(N_REQ) - 1; m_stall = 0;
        hold = '0; v = '0; l = '0;
        exp_sum = 0; exp_cout = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin a[i] = '0; b[i] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!hold[i]) begin
                    v[i] = ($urandom_range(0, 9) < 7);
                    a[i] = 8'($urandom_range(0, 255));
                    b[i] = 8'($urandom_range(0, 255));
                    l[i] = 1'($urandom_range(0, 1));
                end
                set_req(i, v[i], a[i], b[i], l[i]);
            end
            // Scheduler model: who is served this cycle, and what the adder returns.
            g = -1;
            if (m_locked) begin
                if (v[m_owner]) g = m_owner;
            end else begin
                for (int k = 1; k <= int'(N_REQ); k++)
                    if (g < 0 && v[(m_rr + k) % int'(N_REQ)]) g = (m_rr + k) % int'(N_REQ);
            end
            exp_ready = '0;
            exp_to    = 1'b0;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                total    = int'(a[g]) + int'(b[g]) + m_carry;
                exp_sum  = total % 256;
                exp_cout = total / 256;
                m_stall  = 0;
                if (l[g]) begin
                    m_carry = 0; m_locked = 1'b0; m_rr = g;
                end else begin
                    m_carry = exp_cout; m_locked = 1'b1; m_owner = g;
                end
            end
`ifdef ADDER_SCHED_TIMEOUT_EN
            else if (m_locked) begin
                m_stall++;
                if (m_stall == int'(TIMEOUT)) begin
                    m_locked = 1'b0; m_carry = 0; m_rr = m_owner; m_stall = 0; exp_to = 1'b1;
                end
            end
`endif
            #1;
            checks++; if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, req_ready, exp_ready); end
            tick();
            checks++; if (rsp_valid !== exp_ready) begin
                errors++; $display("FAIL rand_rsp_valid cyc %0d got %b exp %b", cyc, rsp_valid, exp_ready); end
            if (g >= 0) begin
                checks++; if (rsp_sum !== 8'(exp_sum) || rsp_cout !== 1'(exp_cout) || rsp_id !== ID_W'(g)) begin
                    errors++; $display("FAIL rand_rsp cyc %0d got sum %0d cout %b id %0d exp %0d %0d %0d",
                                       cyc, rsp_sum, rsp_cout, rsp_id, exp_sum, exp_cout, g); end
            end
            checks++; if (busy !== m_locked || timeout_err !== exp_to) begin
                errors++; $display("FAIL rand_status cyc %0d got busy %b terr %b exp %b %b", cyc, busy, timeout_err, m_locked, exp_to); end
            for (int i = 0; i < int'(N_REQ); i++) hold[i] = v[i] && (g != i);
        end
        clear_reqs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        test_reset();
        test_single_byte();
        test_overflow();
        test_chain();
        test_fairness();
        test_reset_mid_lock();
`ifdef ADDER_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
